mem_port_ctrl: RTL and testbench

Byte-serial memory port controller: arbitrates between the instruction-fetch port and the load/store port, serialises 1/2/4-byte accesses onto the 8-bit RAM bus, and serves instruction fetches from a parametrised 2-way instruction cache. It sits between the IF/MEM stages and the external RAM/IO bus and replaces the fixed 32-set controller with configurable geometry. It adds valid bits, signed loads, store-invalidate coherence, fetch abort and cache flush.

---
 rtl/mem_port_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Byte-serial RAM port controller: arbitrates fetch vs load/store over an 8-bit bus.
// Define ICACHE_EN to add the 2-way instruction cache (SETS sets, LRU replacement).
module mem_port_ctrl #(
    parameter int         ADDR_W = 32,
    parameter int         SETS   = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [31:0]       i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    input  logic              icache_inv,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy
);
    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [1:0]        last;
    logic              fetch, sgn, hit_pend;
    logic              i_done_q, d_done_q, mem_wr_q;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wd, rbuf, rw, rext;

    logic [1:0]        dsz;
    logic              io_f, can_acc, take_d, take_i, hit, rd_end;
    logic [31:0]       hit_data;

    assign dsz     = (d_size == 2'd3) ? 2'd2 : d_size;
    assign io_f    = (i_addr[17:16] == IO_HI);
    // The cycle before a hit's i_done pulse holds off new acceptance.
    assign can_acc = (state == IDLE || state == DONE) && !hit_pend;
    assign take_d  = can_acc && d_req;
    assign take_i  = can_acc && !d_req && i_req && !i_flush;
    assign rd_end  = (state == RD) && !(fetch && i_flush) && (cnt == {1'b0, last} + 3'd1);

    // Final byte comes straight from the bus on the completing edge.
    always_comb begin
        rw = rbuf;
        rw[{last, 3'b000} +: 8] = mem_din;
        case (last)
            2'd0:    rext = {{24{sgn & rw[7]}}, rw[7:0]};
            2'd1:    rext = {{16{sgn & rw[15]}}, rw[15:0]};
            default: rext = rw;
        endcase
    end

`ifdef ICACHE_EN
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [TAG_W-1:0] tag0 [SETS];
    logic [TAG_W-1:0] tag1 [SETS];
    logic [31:0]      dat0 [SETS];
    logic [31:0]      dat1 [SETS];
    logic [SETS-1:0]  vld0, vld1, lru;
    logic [IDX_W-1:0] fidx, sidx, bidx;
    logic [TAG_W-1:0] ftag, stag, btag;
    logic             h0, h1, s0, s1, hit_way, fway, fill_en, io_b;

    assign fidx     = i_addr[IDX_W+1:2];
    assign ftag     = i_addr[ADDR_W-1:IDX_W+2];
    assign sidx     = d_addr[IDX_W+1:2];
    assign stag     = d_addr[ADDR_W-1:IDX_W+2];
    assign bidx     = base[IDX_W+1:2];
    assign btag     = base[ADDR_W-1:IDX_W+2];
    assign io_b     = (base[17:16] == IO_HI);
    assign h0       = vld0[fidx] && (tag0[fidx] == ftag);
    assign h1       = vld1[fidx] && (tag1[fidx] == ftag);
    assign hit      = (h0 || h1) && !io_f;
    assign hit_way  = !h0;
    assign hit_data = h0 ? dat0[fidx] : dat1[fidx];
    assign s0       = vld0[sidx] && (tag0[sidx] == stag);
    assign s1       = vld1[sidx] && (tag1[sidx] == stag);
    assign fway     = lru[bidx];
    assign fill_en  = rdy && rd_end && fetch && !io_b;

    // icache_inv is applied last so it overrides a same-edge fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld0 <= '0;
            vld1 <= '0;
            lru  <= '0;
        end else if (rdy) begin
            if (take_i && hit)
                lru[fidx] <= ~hit_way;
            if (take_d && d_we) begin
                if (s0) vld0[sidx] <= 1'b0;
                if (s1) vld1[sidx] <= 1'b0;
            end
            if (fill_en) begin
                if (fway) vld1[bidx] <= 1'b1;
                else      vld0[bidx] <= 1'b1;
                lru[bidx] <= ~fway;
            end
            if (icache_inv) begin
                vld0 <= '0;
                vld1 <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (fway) begin
                tag1[bidx] <= btag;
                dat1[bidx] <= rw;
            end else begin
                tag0[bidx] <= btag;
                dat0[bidx] <= rw;
            end
        end
    end
`else
    logic unused_ok;
    assign hit       = 1'b0;
    assign hit_data  = '0;
    assign unused_ok = ^{icache_inv, io_f, base, i_addr[IDX_W+1:2]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= '0;
            fetch    <= 1'b0;
            sgn      <= 1'b0;
            hit_pend <= 1'b0;
            base     <= '0;
            wd       <= '0;
            rbuf     <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            mem_wr_q <= 1'b0;
            i_data   <= '0;
            d_rdata  <= '0;
            mem_dout <= '0;
            mem_a    <= '0;
        end else if (rdy) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            if (hit_pend) begin
                hit_pend <= 1'b0;
                i_done_q <= !i_flush;
            end
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    mem_a    <= '0;
                    mem_wr_q <= 1'b0;
                    mem_dout <= '0;
                    if (take_d) begin
                        state    <= d_we ? WR : RD;
                        base     <= d_addr;
                        fetch    <= 1'b0;
                        sgn      <= d_signed;
                        wd       <= d_wdata;
                        last     <= {dsz[1], dsz[1] | dsz[0]};
                        mem_a    <= d_addr;
                        mem_wr_q <= d_we;
                        mem_dout <= d_we ? d_wdata[7:0] : 8'h00;
                    end else if (take_i) begin
                        if (hit) begin
                            hit_pend <= 1'b1;
                            i_data   <= hit_data;
                        end else begin
                            state <= RD;
                            base  <= i_addr;
                            fetch <= 1'b1;
                            sgn   <= 1'b0;
                            last  <= 2'd3;
                            mem_a <= i_addr;
                        end
                    end
                end
                RD: begin
                    if (fetch && i_flush) begin
                        state <= IDLE;
                        mem_a <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt != 3'd0)
                            rbuf[{cnt[1:0] - 2'd1, 3'b000} +: 8] <= mem_din;
                        mem_a <= (cnt < {1'b0, last}) ? mem_a + ADDR_W'(1) : '0;
                        if (rd_end) begin
                            state <= DONE;
                            if (fetch) begin
                                i_data   <= rw;
                                i_done_q <= 1'b1;
                            end else begin
                                d_rdata  <= rext;
                                d_done_q <= 1'b1;
                            end
                        end
                    end
                end
                WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < {1'b0, last}) begin
                        mem_a    <= mem_a + ADDR_W'(1);
                        mem_dout <= wd[{cnt[1:0] + 2'd1, 3'b000} +: 8];
                    end else begin
                        state    <= DONE;
                        mem_a    <= '0;
                        mem_wr_q <= 1'b0;
                        mem_dout <= '0;
                        d_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wr = mem_wr_q & rdy;
    assign i_done = i_done_q & rdy;
    assign d_done = d_done_q & rdy;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a 1-cycle-latency byte RAM frozen by rdy.
// Cache-dependent expectations follow ICACHE_EN.
module tb_mem_port_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        i_req, i_flush, i_done;
    logic [31:0] i_addr, i_data;
    logic        d_req, d_we, d_signed, d_done;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        icache_inv;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, busy;

    logic [7:0]  ram [0:262143];
    logic [31:0] a_log [0:63];
    logic [7:0]  w_log [0:63];
    logic        wr_log [0:63];
    int          n_cmp = 0, n_bad = 0;
    int          nbus, nwr, lat;
    logic        other, seen;

    always #5 clk = ~clk;

    mem_port_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .icache_inv(icache_inv),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
    );

    always @(posedge clk) begin
        if (!rst) begin
            ram[18'h00100] <= 8'h78; ram[18'h00101] <= 8'h56;
            ram[18'h00102] <= 8'h34; ram[18'h00103] <= 8'h12;
            ram[18'h00110] <= 8'h80; ram[18'h00112] <= 8'h34; ram[18'h00113] <= 8'h92;
            ram[18'h00040] <= 8'hEF; ram[18'h00041] <= 8'hBE;
            ram[18'h00042] <= 8'hAD; ram[18'h00043] <= 8'hDE;
            ram[18'h00050] <= 8'h0D; ram[18'h00051] <= 8'hD0;
            ram[18'h00052] <= 8'h0D; ram[18'h00053] <= 8'hF0;
            ram[18'h00060] <= 8'h01; ram[18'h00061] <= 8'h02;
            ram[18'h00062] <= 8'h03; ram[18'h00063] <= 8'h04;
            ram[18'h00204] <= 8'h00; ram[18'h00205] <= 8'h00;
            ram[18'h00206] <= 8'h00; ram[18'h00207] <= 8'h00;
            ram[18'h30000] <= 8'h44; ram[18'h30001] <= 8'h33;
            ram[18'h30002] <= 8'h22; ram[18'h30003] <= 8'h11;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency counts edges from acceptance to the edge that raises done; -1 on timeout.
    task automatic wait_done(input bit is_i, input int stall_at, output int l);
        l = -1; nbus = 0; nwr = 0; other = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            a_log[c] = mem_a; w_log[c] = mem_dout; wr_log[c] = mem_wr;
            if (mem_a != 32'h0) nbus++;
            if (mem_wr) nwr++;
            if (is_i ? d_done : i_done) other = 1'b1;
            if (is_i ? i_done : d_done) begin
                l = c - 1;
                break;
            end
            if (stall_at != 0 && c == stall_at) rdy = 1'b0;
            if (stall_at != 0 && c == stall_at + 3) rdy = 1'b1;
        end
        rdy = 1'b1;
        if (is_i) i_req = 1'b0; else d_req = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input bit sg, output int l);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = a; d_size = sz; d_signed = sg;
        wait_done(1'b0, 0, l);
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] w, output int l);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_size = sz; d_signed = 1'b0; d_wdata = w;
        wait_done(1'b0, 0, l);
        d_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int st, output int l);
        @(negedge clk);
        i_req = 1'b1; i_addr = a;
        wait_done(1'b1, st, l);
    endtask

    initial begin
        int hit_lat, hit_bus;
`ifdef ICACHE_EN
        hit_lat = 1; hit_bus = 0;
`else
        hit_lat = 5; hit_bus = 4;
`endif
        rst = 1'b0; rdy = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
        icache_inv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst mem_wr", 32'(mem_wr), 32'h0);
        chk("rst d_done", 32'(d_done), 32'h0);
        chk("rst i_done", 32'(i_done), 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        chk("rst i_data", i_data, 32'h0);
        chk("rst mem_dout", 32'(mem_dout), 32'h0);
        rst = 1'b1;

        load(32'h100, 2'd2, 1'b0, lat);
        chk("ld_w lat", lat, 5);
        chk("ld_w data", d_rdata, 32'h12345678);
        chk("ld_w a0", a_log[1], 32'h100);
        chk("ld_w a1", a_log[2], 32'h101);
        chk("ld_w a3", a_log[4], 32'h103);
        chk("ld_w tail", a_log[5], 32'h0);
        chk("ld_w nbus", nbus, 4);
        load(32'h110, 2'd0, 1'b1, lat);
        chk("ld_sb lat", lat, 2);
        chk("ld_sb data", d_rdata, 32'hFFFFFF80);
        load(32'h110, 2'd0, 1'b0, lat);
        chk("ld_ub data", d_rdata, 32'h00000080);
        load(32'h112, 2'd1, 1'b1, lat);
        chk("ld_sh lat", lat, 3);
        chk("ld_sh data", d_rdata, 32'hFFFF9234);
        load(32'h100, 2'd3, 1'b1, lat);
        chk("ld_sz3 lat", lat, 5);
        chk("ld_sz3 data", d_rdata, 32'h12345678);

        store(32'h204, 2'd1, 32'h1234BEEF, lat);
        chk("st_h lat", lat, 2);
        chk("st_h nwr", nwr, 2);
        chk("st_h a0", a_log[1], 32'h204);
        chk("st_h b0", 32'(w_log[1]), 32'hEF);
        chk("st_h a1", a_log[2], 32'h205);
        chk("st_h b1", 32'(w_log[2]), 32'hBE);
        chk("st_h wr_done", 32'(wr_log[3]), 32'h0);
        load(32'h204, 2'd2, 1'b0, lat);
        chk("st_h readback", d_rdata, 32'h0000BEEF);

        fetch(32'h40, 0, lat);
        chk("if_miss lat", lat, 5);
        chk("if_miss nbus", nbus, 4);
        chk("if_miss data", i_data, 32'hDEADBEEF);
        fetch(32'h40, 0, lat);
        chk("if_hit lat", lat, hit_lat);
        chk("if_hit nbus", nbus, hit_bus);
        chk("if_hit data", i_data, 32'hDEADBEEF);
        store(32'h40, 2'd0, 32'h000000AA, lat);
        chk("st_b lat", lat, 1);
        fetch(32'h40, 0, lat);
        chk("if_stinv lat", lat, 5);
        chk("if_stinv data", i_data, 32'hDEADBEAA);
        fetch(32'h40, 0, lat);
        chk("if_rehit lat", lat, hit_lat);

        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_size = 2'd2; d_signed = 1'b0;
        i_req = 1'b1; i_addr = 32'h50;
        wait_done(1'b0, 0, lat);
        chk("arb d lat", lat, 5);
        chk("arb d first", 32'(other), 32'h0);
        chk("arb d data", d_rdata, 32'h12345678);
        wait_done(1'b1, 0, lat);
        chk("arb i lat", lat, 5);
        chk("arb i data", i_data, 32'hF00DD00D);

        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h60; seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | i_done;
        end
        i_flush = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk("flush busy", 32'(busy), 32'h0);
        chk("flush mem_a", mem_a, 32'h0);
        i_flush = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | i_done;
        end
        chk("flush no done", 32'(seen), 32'h0);
        fetch(32'h60, 0, lat);
        chk("flush refetch lat", lat, 5);
        chk("flush refetch data", i_data, 32'h04030201);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h60; i_flush = 1'b1; seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | i_done | busy;
        end
        i_req = 1'b0; i_flush = 1'b0;
        chk("flush idle", 32'(seen), 32'h0);

        fetch(32'h30000, 0, lat);
        chk("io lat", lat, 5);
        chk("io nbus", nbus, 4);
        chk("io a0", a_log[1], 32'h30000);
        chk("io a3", a_log[4], 32'h30003);
        chk("io data", i_data, 32'h11223344);
        fetch(32'h30000, 2, lat);
        chk("io stall lat", lat, 8);
        chk("io stall data", i_data, 32'h11223344);
        fetch(32'h30000, 0, lat);
        chk("io nofill lat", lat, 5);

        fetch(32'h50, 0, lat);
        chk("inv pre lat", lat, hit_lat);
        @(negedge clk);
        icache_inv = 1'b1;
        @(negedge clk);
        icache_inv = 1'b0;
        fetch(32'h50, 0, lat);
        chk("inv post lat", lat, 5);
        chk("inv post data", i_data, 32'hF00DD00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
